plic_target: RTL
================

Name: plic_target

Overview:
- Single-context platform-level interrupt controller. Consumes the 32-bit `sources` vector from the IRQ router and drives one external-interrupt line to the hart.
- Per-source gateways capture level interrupts into pending bits. Priority/enable/threshold registers gate them. Claim/complete over a simple register bus closes the loop.
- Sits between the IRQ router and the CPU's MEIP input.

Parameters:
- NSRC, 32, number of source lines; source 0 is reserved and never pends.
- PRIO_W, 3, priority field width; priority 0 means never interrupt.
- ADDR_W, 12, register-bus byte-address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sources  in  NSRC  level interrupt lines, may be asynchronous
- req_valid  in  1  register request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address, word aligned; addr[1:0] ignored
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  read data, valid with resp_valid; 0 for writes
- eip  out  1  external interrupt pending to hart

Behaviour:
- Reset (async, rst_n low) clears synchronizers, pending, in_flight, enable, priority, threshold, best_id and best_prio. Outputs: eip=0, resp_valid=0, resp_rdata=0, req_ready=1.
- Reset mid-transaction drops any outstanding response.
- Input sync: each sources[i] passes through a 2-flop synchronizer. Bit 0 is forced to 0 after sync.
- Gateway, per source i≥1: if synced level=1 and in_flight[i]=0, set pending[i]=1 and in_flight[i]=1.
  - No re-pend until complete, so claim and set can never collide on the same ID.
- Register map (word offsets):
  - 0x000+4*i: priority[i], bits[PRIO_W-1:0], RW. Priority 0 is read-only 0.
  - 0x400: pending bitmap, RO. Writes are ignored.
  - 0x800: enable bitmap, RW. Bit 0 is read-only 0.
  - 0xC00: threshold, bits[PRIO_W-1:0], RW.
  - 0xC04: claim on read / complete on write.
  - Unmapped addresses: read 0, write ignored, still respond.
- Bus handshake:
  - Request accepted in cycle T → resp_valid=1 in T+1 for exactly one cycle.
  - req_ready=0 in T+1, so there is at most one outstanding request.
- Arbiter (registered, 1-cycle latency):
  - Candidates are sources with pending&enable and priority>0.
  - Winner is the highest priority; ties go to the lowest ID.
  - best_id/best_prio are registered each cycle; best_id=0 when there is no candidate.
  - eip is registered: eip=1 iff best_prio>threshold, i.e. 2 cycles after a pending/enable/priority/threshold change.
- Claim (read 0xC04 accepted at T):
  - resp_rdata = best_id if best_prio>threshold, else 0.
  - At T+1, pending[best_id] is cleared; in_flight stays set.
  - Claim returning 0 changes nothing.
- Complete (write 0xC04, ID=wdata[4:0]):
  - If 1≤ID<NSRC and enable[ID]=1, clear in_flight[ID] at T+1.
  - Otherwise ignored silently.
  - A source still asserted re-pends one cycle after in_flight clears.
- Disabling a pending source keeps its pending bit; it only drops out of arbitration.
- Widths: priority and threshold compares are unsigned PRIO_W-bit. wdata upper bits beyond field widths are ignored and read back 0.

Test Plan:
- Reset: assert rst_n=0 mid-request → eip=0, resp_valid=0, all registers read 0 after release; pending reads 0 even with sources=0xFFFF_FFFF held through reset.
- Basic flow: prio[3]=2, enable=0x8, threshold=0, pulse sources[3]=1 → eip=1 within 5 cycles. Claim reads 3; pending bit3 then 0 and eip falls. Complete with 3 while source still high → pending re-sets, eip=1 again.
- Priority/tie: prio[5]=4, prio[2]=4, prio[7]=6, all enabled and pending → claims return 7, then 2, then 5, then 0.
- Threshold: prio[4]=3, threshold=3 → eip=0 and claim=0. Set threshold=2 → eip=1 two cycles later, claim=4.
- Gateway/complete guards: complete with ID 4 while enable[4]=0 → in_flight stays set and no re-pend. Complete with IDs 0 and 31 (not in flight) → no state change.
- Bus/misc: write prio[0]=7, enable=0xFFFF_FFFF → prio[0] reads 0, enable reads 0xFFFF_FFFE. Back-to-back req_valid → req_ready low on each response cycle, one resp per request. Unmapped read 0x900 → resp_rdata=0.

Source files
------------

// File: rtl/plic_target.sv
// plic_target: single-context PLIC with level gateways, priority arbiter and claim/complete bus
module plic_target #(
    parameter int NSRC   = 32,
    parameter int PRIO_W = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   sources,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              eip
);
    localparam int IDW = $clog2(NSRC);
    localparam logic [ADDR_W-1:0] A_PEND = 'h400;
    localparam logic [ADDR_W-1:0] A_EN   = 'h800;
    localparam logic [ADDR_W-1:0] A_THR  = 'hC00;
    localparam logic [ADDR_W-1:0] A_CLM  = 'hC04;

    logic [NSRC-1:0]   sync1, sync2, pending, in_flight, enable;
    logic [NSRC-1:0]   level, set, clr_pend, clr_inf;
    logic [PRIO_W-1:0] prio [NSRC];
    logic [PRIO_W-1:0] threshold, best_prio, nb_prio;
    logic [IDW-1:0]    best_id, nb_id, idx, claim_id, cmpl_id;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       rdata;
    logic              acc, is_prio, do_claim, cmpl_ok;
    logic              unused_bits;

    assign unused_bits = ^{req_addr[1:0], sync2[0]};
    assign req_ready   = !resp_valid;
    assign acc         = req_valid && req_ready;
    assign waddr       = {req_addr[ADDR_W-1:2], 2'b00};
    assign idx         = req_addr[2 +: IDW];
    assign is_prio     = waddr < ADDR_W'(NSRC * 4);
    assign claim_id    = (best_prio > threshold) ? best_id : '0;
    assign do_claim    = acc && !req_we && waddr == A_CLM && claim_id != '0;
    assign cmpl_id     = req_wdata[IDW-1:0];
    assign cmpl_ok     = acc && req_we && waddr == A_CLM && cmpl_id != '0 &&
                         32'(cmpl_id) < NSRC && enable[cmpl_id];
    // Source 0 is reserved, so its synchronized level is masked off before the gateway.
    assign level       = {sync2[NSRC-1:1], 1'b0};
    assign set         = level & ~in_flight;
    assign clr_pend    = do_claim ? (NSRC'(1) << claim_id) : '0;
    assign clr_inf     = cmpl_ok ? (NSRC'(1) << cmpl_id) : '0;

    // Read-data mux for the register map; unmapped words read 0.
    always_comb begin
        rdata = is_prio          ? 32'(prio[idx]) :
                waddr == A_PEND  ? 32'(pending)   :
                waddr == A_EN    ? 32'(enable)    :
                waddr == A_THR   ? 32'(threshold) :
                waddr == A_CLM   ? 32'(claim_id)  : '0;
    end

    // Highest priority wins; scanning upward with strict '>' keeps the lowest ID on ties.
    always_comb begin
        nb_id   = '0;
        nb_prio = '0;
        for (int i = 1; i < NSRC; i++)
            if (pending[i] && enable[i] && prio[i] > nb_prio) begin
                nb_id   = IDW'(i);
                nb_prio = prio[i];
            end
    end

    // Synchronizers and gateways; a source cannot re-pend until its completion clears in_flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            pending   <= '0;
            in_flight <= '0;
        end else begin
            sync1     <= sources;
            sync2     <= sync1;
            pending   <= (pending | set) & ~clr_pend;
            in_flight <= (in_flight & ~clr_inf) | set;
        end
    end

    // Programmable registers; priority 0 and enable bit 0 stay hard-wired to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) prio[i] <= '0;
            enable    <= '0;
            threshold <= '0;
        end else if (acc && req_we) begin
            if (is_prio && idx != '0) prio[idx] <= req_wdata[PRIO_W-1:0];
            if (waddr == A_EN) enable <= {req_wdata[NSRC-1:1], 1'b0};
            if (waddr == A_THR) threshold <= req_wdata[PRIO_W-1:0];
        end
    end

    // Registered arbiter result and interrupt line to the hart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_id   <= '0;
            best_prio <= '0;
            eip       <= 1'b0;
        end else begin
            best_id   <= nb_id;
            best_prio <= nb_prio;
            eip       <= best_prio > threshold;
        end
    end

    // One-cycle response strobe for every accepted request; writes return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= acc;
            resp_rdata <= (acc && !req_we) ? rdata : '0;
        end
    end
endmodule
